seg_scan_display: RTL and testbench



---
 rtl/seg_scan_display.sv | 127 ++++++++++++
 tb/tb_seg_scan_display.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/seg_scan_display.sv
// Four-digit multiplexed common-anode seven-segment scanner. The BCD word is
// latched once per scan frame; each digit slot opens with an all-off guard.
module seg_scan_display #(
  parameter int SCAN_CYC  = 50000,
  parameter int GUARD_CYC = 500,
  parameter int DP_POS    = 4,
  parameter int LZB_EN    = 1
) (
  input  logic        sys_clk50m,
  input  logic        sys_rst,
  input  logic [15:0] data,
  output logic [3:0]  sel,
  output logic [7:0]  seg,
  output logic        frame_tick
);

  localparam int            CW        = (SCAN_CYC > 1) ? $clog2(SCAN_CYC) : 1;
  localparam logic [CW-1:0] CNT_LAST  = CW'(SCAN_CYC - 1);
  localparam logic [CW-1:0] CNT_GUARD = CW'(GUARD_CYC);

  logic [CW-1:0] r_cnt;
  logic [1:0]    r_idx;
  logic [15:0]   r_snap;
  logic [3:0]    r_sel;
  logic [7:0]    r_seg;
  logic          r_frame_tick;

  logic          w_wrap;
  logic          w_active;
  logic          w_blank;
  logic          w_dp;
  logic [3:0]    w_digit;
  logic [3:0]    w_sel;
  logic [7:0]    w_seg;

  function automatic logic [7:0] seg_decode(input logic [3:0] v);
    logic [7:0] s;
    case (v)
      4'd0:    s = 8'hC0;
      4'd1:    s = 8'hF9;
      4'd2:    s = 8'hA4;
      4'd3:    s = 8'hB0;
      4'd4:    s = 8'h99;
      4'd5:    s = 8'h92;
      4'd6:    s = 8'h82;
      4'd7:    s = 8'hF8;
      4'd8:    s = 8'h80;
      4'd9:    s = 8'h90;
      default: s = 8'hBF;
    endcase
    return s;
  endfunction

  // True when digit k and every digit above it are zero (codes > 9 count as nonzero).
  function automatic logic upper_zero(input logic [15:0] s, input logic [1:0] k);
    return ((s >> {k, 2'b00}) == 16'h0000);
  endfunction

  assign w_wrap   = (r_cnt == CNT_LAST);
  assign w_active = (r_cnt >= CNT_GUARD);
  assign w_digit  = r_snap[{r_idx, 2'b00} +: 4];
  assign w_dp     = (int'(r_idx) == DP_POS);
  assign w_blank  = (LZB_EN == 1) && (r_idx != 2'd0) &&
                    ((DP_POS > 3) || (int'(r_idx) > DP_POS)) &&
                    upper_zero(r_snap, r_idx);

  // Next-cycle digit enable and segment pattern for the current slot phase.
  always_comb begin
    w_sel = 4'hF;
    w_seg = 8'hFF;
    if (w_active) begin
      w_sel = ~(4'b0001 << r_idx);
      if (w_blank) begin
        w_seg = 8'hFF;
      end else begin
        w_seg = seg_decode(w_digit);
        if (w_dp) begin
          w_seg[7] = 1'b0;
        end else begin
          w_seg[7] = w_seg[7];
        end
      end
    end else begin
      w_sel = 4'hF;
      w_seg = 8'hFF;
    end
  end

  // Slot counter, digit index and once-per-frame snapshot of the BCD word.
  always_ff @(posedge sys_clk50m or negedge sys_rst) begin
    if (!sys_rst) begin
      r_cnt        <= '0;
      r_idx        <= 2'd0;
      r_snap       <= 16'h0000;
      r_frame_tick <= 1'b0;
    end else begin
      r_frame_tick <= w_wrap && (r_idx == 2'd3);
      if (w_wrap) begin
        r_cnt <= '0;
        r_idx <= r_idx + 2'd1;
        if (r_idx == 2'd3) begin
          r_snap <= data;
        end else begin
          r_snap <= r_snap;
        end
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  // Registered display drive.
  always_ff @(posedge sys_clk50m or negedge sys_rst) begin
    if (!sys_rst) begin
      r_sel <= 4'hF;
      r_seg <= 8'hFF;
    end else begin
      r_sel <= w_sel;
      r_seg <= w_seg;
    end
  end

  assign sel        = r_sel;
  assign seg        = r_seg;
  assign frame_tick = r_frame_tick;

endmodule

// File: tb/tb_seg_scan_display.sv
// Bench for seg_scan_display: two instances (no decimal point, decimal point on
// digit 1) run in lockstep from one clock, reset and data word.
module tb_seg_scan_display;

  logic        clk   = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] data  = 16'h0000;
  logic [3:0]  sel, sel_dp;
  logic [7:0]  seg, seg_dp;
  logic        ft, ft_dp;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] data;
    logic [31:0] e;   // {digit3, digit2, digit1, digit0} segments, no decimal point
    logic [31:0] d;   // same with the decimal point on digit 1
  } vec_t;

  typedef struct {
    logic [3:0] sel;
    logic [7:0] seg;
    logic [7:0] seg_dp;
  } exp_t;

  vec_t vt [7];
  exp_t sb [$];

  always #5 clk = ~clk;

  seg_scan_display #(.SCAN_CYC(20), .GUARD_CYC(4), .DP_POS(4), .LZB_EN(1)) dut (
    .sys_clk50m(clk), .sys_rst(rst_n), .data(data),
    .sel(sel), .seg(seg), .frame_tick(ft)
  );

  seg_scan_display #(.SCAN_CYC(20), .GUARD_CYC(4), .DP_POS(1), .LZB_EN(1)) dut_dp (
    .sys_clk50m(clk), .sys_rst(rst_n), .data(data),
    .sel(sel_dp), .seg(seg_dp), .frame_tick(ft_dp)
  );

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  task automatic wait_sel(input logic [3:0] s, input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (sel == s) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_ft(input int lim, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < lim; i++) begin
      if (ft) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  initial begin
    bit         ok;
    int         npulse;
    logic [3:0] s;

    vt[0] = '{16'h0123, 32'hFFF9A4B0, 32'hFFF924B0};
    vt[1] = '{16'h0000, 32'hFFFFFFC0, 32'hFFFF40C0};
    vt[2] = '{16'h1A05, 32'hF9BFC092, 32'hF9BF4092};
    vt[3] = '{16'h8000, 32'h80C0C0C0, 32'h80C040C0};
    vt[4] = '{16'h00F0, 32'hFFFFBFC0, 32'hFFFF3FC0};
    vt[5] = '{16'h9876, 32'h9080F882, 32'h90807882};
    vt[6] = '{16'h0005, 32'hFFFFFF92, 32'hFFFF4092};

    // Reset state and exact slot timing after release.
    repeat (3) tick();
    chk("rst sel", sel, 4'hF);
    chk("rst seg", seg, 8'hFF);
    chk("rst ft", ft, 1'b0);
    chk("rst sel_dp", sel_dp, 4'hF);
    chk("rst seg_dp", seg_dp, 8'hFF);
    rst_n = 1'b1;
    for (int k = 1; k <= 85; k++) begin
      tick();
      if (k <= 4) begin
        chk("guard sel", sel, 4'hF);
        chk("guard seg", seg, 8'hFF);
      end
      case (k)
        5:  begin chk("c5 sel", sel, 4'hE); chk("c5 seg", seg, 8'hC0); chk("c5 seg_dp", seg_dp, 8'hC0); end
        20: chk("c20 sel", sel, 4'hE);
        21: chk("c21 sel", sel, 4'hF);
        25: begin chk("c25 sel", sel, 4'hD); chk("c25 seg", seg, 8'hFF);
                  chk("c25 sel_dp", sel_dp, 4'hD); chk("c25 seg_dp", seg_dp, 8'h40); end
        45: begin chk("c45 sel", sel, 4'hB); chk("c45 seg", seg, 8'hFF); end
        65: begin chk("c65 sel", sel, 4'h7); chk("c65 seg", seg, 8'hFF); end
        79: chk("c79 ft", ft, 1'b0);
        80: begin chk("c80 ft", ft, 1'b1); chk("c80 sel", sel, 4'h7); end
        81: begin chk("c81 ft", ft, 1'b0); chk("c81 sel", sel, 4'hF); end
        85: chk("c85 sel", sel, 4'hE);
        default: ;
      endcase
    end

    // Table-driven frames through the scoreboard.
    for (int i = 0; i < 7; i++) begin
      data = vt[i].data;
      wait_ft(200, ok);
      chk("frame_tick seen", ok, 1'b1);
      tick();
      for (int k = 0; k < 4; k++) begin
        s = 4'hF;
        s[k] = 1'b0;
        sb.push_back('{s, vt[i].e[k*8 +: 8], vt[i].d[k*8 +: 8]});
      end
      while (sb.size() > 0) begin
        exp_t x;
        x = sb.pop_front();
        wait_sel(x.sel, 40, ok);
        chk("slot reached", ok, 1'b1);
        chk("vec seg", seg, x.seg);
        chk("vec sel_dp", sel_dp, x.sel);
        chk("vec seg_dp", seg_dp, x.seg_dp);
      end
    end

    // Mid-frame data change stays invisible until the frame boundary.
    data = 16'h0042;
    wait_ft(200, ok);
    chk("frame_tick 42", ok, 1'b1);
    tick();
    wait_sel(4'hD, 40, ok);
    chk("reach d1", ok, 1'b1);
    data = 16'h0077;
    chk("old d1", seg, 8'h99);
    chk("old d1 dp", seg_dp, 8'h19);
    wait_sel(4'hB, 40, ok);
    chk("old d2", seg, 8'hFF);
    wait_sel(4'h7, 40, ok);
    chk("old d3", seg, 8'hFF);
    npulse = 0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (ft) npulse++;
      if (sel == 4'hE) break;
    end
    chk("ft pulse count", npulse, 1);
    chk("new d0", seg, 8'hF8);
    wait_sel(4'hD, 40, ok);
    chk("new d1", seg, 8'hF8);
    chk("new d1 dp", seg_dp, 8'h78);

    // Asynchronous reset during digit-2 active phase.
    wait_sel(4'hB, 80, ok);
    chk("reach d2", ok, 1'b1);
    tick();
    #2 rst_n = 1'b0;
    #1;
    chk("async sel", sel, 4'hF);
    chk("async seg", seg, 8'hFF);
    chk("async sel_dp", sel_dp, 4'hF);
    chk("async seg_dp", seg_dp, 8'hFF);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k <= 4) begin
        chk("post-rst guard sel", sel, 4'hF);
      end else begin
        chk("post-rst sel", sel, 4'hE);
        chk("post-rst seg", seg, 8'hC0);
        chk("post-rst seg_dp", seg_dp, 8'hC0);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
